// File: rtl/cache_responder.sv
// Byte-addressed memory responder: read/write commands answered by one or two response beats.
// Latency: LATENCY+1 cycles from command beat to first response (LATENCY+2 for WRITE32).
// Backpressure: none; commands arriving while busy are dropped, never queued.
module cache_responder #(
    parameter int ADDR_BITS = 19,
    parameter int LATENCY   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           C,
    input  logic [ADDR_BITS-1:0] A,
    input  logic [15:0]          D,
    output logic [3:0]           C_out,
    output logic [15:0]          D_out,
    output logic                 busy
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    localparam logic [3:0] CMD_READ8   = 4'd1;
    localparam logic [3:0] CMD_READ16  = 4'd2;
    localparam logic [3:0] CMD_READ32  = 4'd3;
    localparam logic [3:0] CMD_WRITE8  = 4'd5;
    localparam logic [3:0] CMD_WRITE16 = 4'd6;
    localparam logic [3:0] CMD_WRITE32 = 4'd7;
    localparam logic [3:0] CMD_RESP    = 4'd7;

    typedef enum logic [2:0] {IDLE, WBEAT2, WAIT, RESP1, RESP2} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cmd_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [15:0]          hi_q;
    logic [15:0]          lo_q;
    logic [7:0]           cnt_q;
    logic                 cmd_valid;

    logic [7:0]           mem [DEPTH];

    // Consecutive byte addresses; wrap naturally at the top of the address space.
    logic [ADDR_BITS-1:0] addr1, addr2, addr3;
    assign addr1 = addr_q + ADDR_BITS'(1);
    assign addr2 = addr_q + ADDR_BITS'(2);
    assign addr3 = addr_q + ADDR_BITS'(3);

    // Only the six defined read/write codes start a transaction; NOP and reserved codes are ignored.
    always_comb begin
        cmd_valid = 1'b0;
        case (C)
            CMD_READ8, CMD_READ16, CMD_READ32,
            CMD_WRITE8, CMD_WRITE16, CMD_WRITE32: cmd_valid = 1'b1;
            default:                              cmd_valid = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and response outputs; outputs are forced quiet while reset is held.
    always_comb begin
        state_nxt = state;
        C_out     = 4'd0;
        D_out     = 16'd0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = (C == CMD_WRITE32) ? WBEAT2 : WAIT;
            end
            WBEAT2: state_nxt = WAIT;
            WAIT: begin
                if (cnt_q == 8'd0) state_nxt = RESP1;
            end
            RESP1: begin
                C_out = CMD_RESP;
                case (cmd_q)
                    CMD_READ8:              D_out = {8'h00, mem[addr_q]};
                    CMD_READ16, CMD_READ32: D_out = {mem[addr_q], mem[addr1]};
                    default:                D_out = 16'd0;
                endcase
                state_nxt = (cmd_q == CMD_READ32) ? RESP2 : IDLE;
            end
            RESP2: begin
                C_out     = CMD_RESP;
                D_out     = {mem[addr2], mem[addr3]};
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            C_out = 4'd0;
            D_out = 16'd0;
            busy  = 1'b0;
        end
    end

    // Request capture and wait counter: command beat in IDLE, low write half in WBEAT2.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= 4'd0;
            addr_q <= '0;
            hi_q   <= 16'd0;
            lo_q   <= 16'd0;
            cnt_q  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q  <= C;
                        addr_q <= A;
                        hi_q   <= D;
                        cnt_q  <= CNT_LOAD;
                    end
                end
                WBEAT2: begin
                    lo_q  <= D;
                    cnt_q <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Writes commit at the edge leaving RESP1 (big-endian byte order); memory itself is never reset.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP1) begin
            case (cmd_q)
                CMD_WRITE8: mem[addr_q] <= hi_q[7:0];
                CMD_WRITE16: begin
                    mem[addr_q] <= hi_q[15:8];
                    mem[addr1]  <= hi_q[7:0];
                end
                CMD_WRITE32: begin
                    mem[addr_q] <= hi_q[15:8];
                    mem[addr1]  <= hi_q[7:0];
                    mem[addr2]  <= lo_q[15:8];
                    mem[addr3]  <= lo_q[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cache_responder.md
CACHE_RESPONDER -- requirements
Module: cache_responder

Interface
REQ-001 Parameter ADDR_BITS, default 19: byte-address width; the backing store holds 2^ADDR_BITS bytes.
REQ-002 Parameter LATENCY, default 6: wait cycles between the last request beat and the first response beat (legal range 1..255).
REQ-003 clk  in  1  single clock; all logic samples on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 C  in  4  request command: 0 NOP, 1 READ8, 2 READ16, 3 READ32, 5 WRITE8, 6 WRITE16, 7 WRITE32; the codes 4 and 8..15 are reserved.
REQ-006 A  in  ADDR_BITS  request byte address, sampled with the command beat.
REQ-007 D  in  16  request write data.
REQ-008 C_out  out  4  response command: 0 NOP, 7 RESPONSE.
REQ-009 D_out  out  16  response read data.
REQ-010 busy  out  1  high from the cycle after a command is accepted until the last response beat.

Function
REQ-011 FSM states: IDLE, WBEAT2, WAIT, RESP1, RESP2.
REQ-012 IDLE: on a valid command (codes 1,2,3,5,6,7), the block latches C, A and D[15:0] into the address and data registers.
- WRITE32 goes to WBEAT2.
- Every other valid command goes to WAIT, with the counter loaded to LATENCY-1.
REQ-013 In IDLE, NOP and the reserved codes are ignored, with no state change.
REQ-014 WBEAT2: in the next cycle the block latches D as the low half of WRITE32; D at the command beat is the high half. C and A are ignored in this cycle. The FSM then goes to WAIT, with the counter loaded to LATENCY-1.
REQ-015 WAIT: the counter decrements each cycle; when it reaches 0, the FSM goes to RESP1.
REQ-016 RESP1 drives C_out=7 for exactly one cycle, with D_out as follows:
- READ8: D_out = {8'h00, mem[A]}.
- READ16: D_out = {mem[A], mem[A+1]} (big-endian).
- READ32: D_out = {mem[A], mem[A+1]}; the FSM then goes to RESP2.
- Writes: D_out = 0.
All commands except READ32 return to IDLE after RESP1.
REQ-017 RESP2 (READ32 only): C_out=7 and D_out = {mem[A+2], mem[A+3]} for one cycle; the FSM then goes to IDLE.
REQ-018 Writes commit on the RESP1 edge, so a read issued afterward observes them:
- WRITE8: mem[A] = D[7:0].
- WRITE16: mem[A], mem[A+1] = D[15:8], D[7:0].
- WRITE32: mem[A..A+3] = hi[15:8], hi[7:0], lo[15:8], lo[7:0].
REQ-019 Address arithmetic A+k wraps modulo 2^ADDR_BITS; no alignment check is made and unaligned accesses are legal.
REQ-020 Outside RESP1/RESP2, C_out=0 and D_out=0.
REQ-021 Any command presented while busy=1 (other than the WBEAT2 data beat) is ignored and dropped, with no queuing.
REQ-022 A new command may be accepted in the same cycle that IDLE is re-entered, i.e. the cycle after the last response beat, not during it.
REQ-023 Minimum request-to-first-response latency, counted from the command-beat edge:
- LATENCY+1 cycles for single-beat commands.
- LATENCY+2 cycles for WRITE32.

Reset
REQ-024 While reset=1, the FSM goes to IDLE and C_out=0, D_out=0, busy=0, and the counter and latched registers clear to 0.
REQ-025 Reset takes priority over every other event in the same cycle; a command presented with reset=1 is not accepted.
REQ-026 Reset mid-operation aborts the transaction without a response; an aborted write never commits.
REQ-027 Memory contents are not cleared by reset.
REQ-028 Initial memory contents are loadable by the bench through hierarchical access or $readmemh; unloaded bytes are undefined.

Verification
REQ-029 WRITE32 at A=0x00800 with D=0x1234 then D=0x5678, LATENCY=6 -> after the command edge, 7 cycles of C_out=0, then one cycle C_out=7, D_out=0, then busy=0.
REQ-030 READ32 at A=0x00800 after REQ-029 -> C_out=7 with D_out=0x1234, then C_out=7 with D_out=0x5678 on consecutive cycles, then C_out=0.
REQ-031 READ8 at A=0x00801 and READ16 at A=0x00801 after REQ-029 -> D_out=0x0034 and D_out=0x3456 respectively.
REQ-032 WRITE16 at A=0x7FFFF with D=0xABCD, then READ16 at 0x7FFFF -> D_out=0xABCD; mem[0x00000]=0xCD (wrap-around).
REQ-033 Issue READ8 and, while busy=1, present WRITE8 at the same address with D=0x00FF -> exactly one response occurs (the read's) and memory is unchanged.
REQ-034 Assert reset in WAIT of a WRITE8 with D=0x0055 -> no C_out=7 response, busy=0 the cycle after reset, and a subsequent READ8 returns the old byte.
